// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: state
// encoding, opcode values, ALU/mux select codes and the control bundle.
package mc_pkg;

    // Controller states; 4 bits leave room for unused encodings that the
    // next-state logic steers back to FETCH.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    // Supported opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    // Operation requests for the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic addiu;
        logic illegal;
    } op_class_t;

    // Every datapath control the FSM drives, grouped so the reset gate is one line
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ct_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_main_ctrl_op_decode.sv
// Combinational opcode classifier: maps the IR opcode field onto a one-hot
// instruction class; anything unrecognised raises the illegal bit.
module mc_op_decode
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] opcode,
    output op_class_t       op_class
);

    // Exactly one class bit is set for any opcode value
    always_comb begin
        op_class         = '0;
        op_class.rtype   = (opcode == OP_W'(OP_RTYPE));
        op_class.lw      = (opcode == OP_W'(OP_LW));
        op_class.sw      = (opcode == OP_W'(OP_SW));
        op_class.beq     = (opcode == OP_W'(OP_BEQ));
        op_class.j       = (opcode == OP_W'(OP_J));
        op_class.addiu   = (opcode == OP_W'(OP_ADDIU));
        op_class.illegal = ~(op_class.rtype | op_class.lw | op_class.sw |
                             op_class.beq | op_class.j | op_class.addiu);
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main controller for the single-ALU MIPS datapath. Controls
// are decoded from the state register (with memory-completion qualified
// by mem_ready) and forced low while reset is held.
module mc_main_ctrl
    import mc_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_ct_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    op_class_t        op_class;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;

    // The branch decision is made in the datapath from pc_write_cond and zero
    logic unused_zero;
    assign unused_zero = zero;

    mc_op_decode #(
        .OP_W (OP_W)
    ) u_op_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // Next-state, retire strobe and per-state control decode
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        ctrl    = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ct_op = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_ct_op = ALUOP_ADD;
                if (op_class.lw || op_class.sw) begin
                    state_d = ST_MEM_ADDR;
                end else if (op_class.rtype) begin
                    state_d = ST_EXEC_R;
                end else if (op_class.beq) begin
                    state_d = ST_BRANCH;
                end else if (op_class.j) begin
                    state_d = ST_JUMP;
                end else if (op_class.addiu) begin
                    state_d = ST_EXEC_I;
                end else begin
                    ctrl.illegal_op = 1'b1;
                    state_d         = ST_FETCH;
                end
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ct_op = ALUOP_ADD;
                state_d        = op_class.sw ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                retire          = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_ct_op = ALUOP_FUNCT;
                state_d        = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                retire          = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ct_op = ALUOP_ADD;
                state_d        = ST_I_WB;
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                retire         = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_ct_op     = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                retire             = 1'b1;
                state_d            = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                retire         = 1'b1;
                state_d        = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Retired-instruction count wraps naturally at its width
    always_comb begin
        cnt_d = cnt_q + CNT_W'(retire);
    end

    // State and counter registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold every control low while reset is asserted, FETCH included
    always_comb begin
        ctrl_out = rst ? ctrl : '0;
    end

    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign i_or_d        = ctrl_out.i_or_d;
    assign ir_write      = ctrl_out.ir_write;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_source     = ctrl_out.pc_source;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_ct_op     = ctrl_out.alu_ct_op;
    assign reg_dst       = ctrl_out.reg_dst;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_write     = ctrl_out.reg_write;
    assign illegal_op    = ctrl_out.illegal_op;
    assign instr_retired = cnt_q;

endmodule
